// File: rtl/ring_bus_pkg.sv
// Shared types and constants for the ring bus master and its arbiter.
package ring_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Control field layout is {R/W, ACK}
    localparam int unsigned CTRL_RW_BIT  = 1;
    localparam int unsigned CTRL_ACK_BIT = 0;

    localparam logic [1:0] CTRL_IDLE = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-granted side loses a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/ring_bus_master.sv
// Single-outstanding master for a daisy-chained register ring with ACK timeout.
module ring_bus_master
    import ring_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_wdata,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        bus_d_out,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [1:0]        bus_ctrl_out,
    input  logic [7:0]        bus_d_in,
    input  logic [1:0]        bus_ctrl_in
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cap_rw;
    logic              cap_id;
    logic [1:0]        grant;
    logic              accept;
    logic              ack;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic              unused_ctrl;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept     = (state == ST_IDLE) && (grant != 2'b00);
    assign req0_ready = rst_n && (state == ST_IDLE) && grant[0];
    assign req1_ready = rst_n && (state == ST_IDLE) && grant[1];

    assign sel_rw    = grant[1] ? req1_rw    : req0_rw;
    assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
    assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;

    // Case equality so an undriven (x/z) chain tail never counts as ACK
    assign ack = (bus_ctrl_in[CTRL_ACK_BIT] === 1'b1);
    // The R/W bit echoed by the tail carries nothing the master needs
    assign unused_ctrl = bus_ctrl_in[CTRL_RW_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            cap_rw       <= RW_WRITE;
            cap_id       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            bus_d_out    <= '0;
            bus_addr     <= '0;
            bus_ctrl_out <= CTRL_IDLE;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_rw                     <= sel_rw;
                        cap_id                     <= grant[1];
                        bus_addr                   <= sel_addr;
                        bus_d_out                  <= (sel_rw == RW_READ) ? '0 : sel_wdata;
                        bus_ctrl_out[CTRL_RW_BIT]  <= sel_rw;
                        bus_ctrl_out[CTRL_ACK_BIT] <= 1'b0;
                        state                      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // ACK is checked first so it wins on the last permitted cycle
                    if (ack || (wait_cnt == LAST_WAIT)) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= cap_id;
                        rsp_err      <= !ack;
                        rsp_rdata    <= (ack && (cap_rw == RW_READ)) ? bus_d_in : '0;
                        bus_d_out    <= '0;
                        bus_addr     <= '0;
                        bus_ctrl_out <= CTRL_IDLE;
                        state        <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_id    <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_bus_master.sv
// Directed self-checking bench for ring_bus_master.
module tb_ring_bus_master;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_rw, req0_ready;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_rw, req1_ready;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_d_out, bus_addr, bus_d_in;
    logic [1:0] bus_ctrl_out, bus_ctrl_in;

    int checks = 0;
    int errors = 0;

    ring_bus_master #(
        .TIMEOUT_CYC (16),
        .ADDR_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_rw      (req0_rw),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_rw      (req1_rw),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus_d_out    (bus_d_out),
        .bus_addr     (bus_addr),
        .bus_ctrl_out (bus_ctrl_out),
        .bus_d_in     (bus_d_in),
        .bus_ctrl_in  (bus_ctrl_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic valid, input logic rw,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (id) begin
            req1_valid = valid; req1_rw = rw; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = valid; req0_rw = rw; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // Starts at a negedge with the master idle; ack_at = WAIT cycle carrying ACK (0 = never)
    task automatic txn(input string tag, input bit id, input logic rw, input logic [7:0] addr,
                       input logic [7:0] wdata, input int ack_at, input logic [7:0] tail_data,
                       input bit zmode);
        int         waits;
        bit         seen;
        bit         exp_err;
        int         exp_waits;
        logic [7:0] exp_rdata;
        exp_err   = (ack_at < 1) || (ack_at > 16);
        exp_waits = exp_err ? 16 : ack_at;
        exp_rdata = (!exp_err && rw) ? tail_data : 8'h00;

        set_req(id, 1'b1, rw, addr, wdata);
        bus_ctrl_in = 2'b01;
        bus_d_in    = 8'hEE;
        #1;
        check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);

        @(negedge clk);
        set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check({tag, "_issue_ready"}, id ? req1_ready : req0_ready, 0);
        check({tag, "_issue_ctrl"}, bus_ctrl_out, {rw, 1'b0});
        check({tag, "_issue_addr"}, bus_addr, addr);
        check({tag, "_issue_dout"}, bus_d_out, rw ? 8'h00 : wdata);
        check({tag, "_issue_rsp"}, rsp_valid, 0);

        waits = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                waits++;
                check({tag, "_wait_ctrl"}, bus_ctrl_out, {rw, 1'b0});
                if (waits == ack_at) begin
                    bus_ctrl_in = 2'b01;
                    bus_d_in    = tail_data;
                end else begin
                    bus_ctrl_in = zmode ? 2'bzz : 2'b00;
                    bus_d_in    = 8'hC3;
                end
            end
        end
        check({tag, "_rsp_seen"}, seen, 1);
        check({tag, "_wait_cycles"}, waits, exp_waits);
        check({tag, "_rsp_id"}, rsp_id, id);
        check({tag, "_rsp_err"}, rsp_err, exp_err);
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_resp_bus_ctrl"}, bus_ctrl_out, 2'b10);
        check({tag, "_resp_bus_addr"}, bus_addr, 8'h00);
        bus_ctrl_in = 2'b00;
        bus_d_in    = 8'h00;

        @(negedge clk);
        check({tag, "_rsp_one_cycle"}, rsp_valid, 0);
    endtask

    initial begin
        logic [1:0] r;
        bit         prev;
        int         n;

        rst_n       = 1'b0;
        bus_ctrl_in = 2'b01;
        bus_d_in    = 8'h5A;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h11);
        set_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h22);
        repeat (3) @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_bus_ctrl", bus_ctrl_out, 2'b10);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_dout", bus_d_out, 0);

        // Both requesters held valid from reset release; tail ACKs immediately
        rst_n = 1'b1;
        prev  = 1'b0;
        n     = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            r = {req1_ready, req0_ready};
            if (r != 2'b00) begin
                check("arb_grant", r, (n % 2 == 0) ? 2'b01 : 2'b10);
                n++;
            end
            if (prev) check("arb_ready_pulse", r, 2'b00);
            prev = (r != 2'b00);
            @(negedge clk);
        end
        check("arb_grant_count", n, 4);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (8) @(negedge clk);
        bus_ctrl_in = 2'b00;
        #1;
        check("drain_rsp_valid", rsp_valid, 0);
        check("drain_bus_ctrl", bus_ctrl_out, 2'b10);
        @(negedge clk);

        txn("wr0",       1'b0, 1'b0, 8'h03, 8'hA5, 2,  8'h00, 1'b0);
        txn("rd1",       1'b1, 1'b1, 8'h03, 8'h00, 1,  8'hA5, 1'b0);
        txn("rd_tmo",    1'b0, 1'b1, 8'h7F, 8'h00, 0,  8'h00, 1'b0);
        txn("rd_ack16",  1'b1, 1'b1, 8'h7F, 8'h00, 16, 8'h3C, 1'b0);
        txn("wr_ack16",  1'b0, 1'b0, 8'h44, 8'h81, 16, 8'hFF, 1'b0);
        txn("rd_zz",     1'b0, 1'b1, 8'h55, 8'h00, 0,  8'h00, 1'b1);

        // Reset while the master is waiting for ACK
        set_req(1'b0, 1'b1, 1'b1, 8'h11, 8'h00);
        #1;
        check("mid_rst_accept", req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("mid_rst_in_wait", bus_ctrl_out, 2'b10);
        rst_n = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 8'h22, 8'h99);
        bus_ctrl_in = 2'b01;
        #1;
        check("mid_rst_bus_ctrl", bus_ctrl_out, 2'b10);
        check("mid_rst_bus_addr", bus_addr, 0);
        check("mid_rst_bus_dout", bus_d_out, 0);
        check("mid_rst_ready1", req1_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("mid_rst_hold_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        bus_ctrl_in = 2'b00;
        @(negedge clk);
        check("post_rst_no_rsp", rsp_valid, 0);
        txn("post_rst_wr1", 1'b1, 1'b0, 8'h22, 8'h99, 1, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
